// File: rtl/exu_muldiv.sv
// exu_muldiv: RV32M multiply/divide unit for the execute stage.
// Multiplies finish one cycle after acceptance. Divides run a radix-2 restoring
// loop for XLEN cycles. Divide-by-zero and signed overflow finish without iterating.
// Optional build macro MULDIV_ITER_MUL_EN replaces the combinational multiplier
// with an XLEN-cycle shift-add loop. Results are the same in both builds.
module exu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            n_rst_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] result_o,
  output logic            done_o,
  output logic            stall_req_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   ITER_COUNT = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG    = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t state, state_next;

  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvsr_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            rem_sel_q;

  // Operand decode for the op being offered in IDLE
  logic            accept;
  logic            is_div;
  logic            div_signed;
  logic            mul_a_signed;
  logic            mul_b_signed;
  logic            a_sign;
  logic            b_sign;
  logic [XLEN-1:0] rs1_mag;
  logic [XLEN-1:0] rs2_mag;
  logic            div_zero;
  logic            div_ovf;

  assign accept       = (state == S_IDLE) & start_i & ~flush_i;
  assign is_div       = op_i[2];
  assign div_signed   = is_div & ~op_i[0];
  assign mul_a_signed = ~is_div & ((op_i[1:0] == 2'b01) | (op_i[1:0] == 2'b10));
  assign mul_b_signed = ~is_div & (op_i[1:0] == 2'b01);
  assign a_sign       = (div_signed | mul_a_signed) & rs1_i[XLEN-1];
  assign b_sign       = (div_signed | mul_b_signed) & rs2_i[XLEN-1];
  assign rs1_mag      = a_sign ? -rs1_i : rs1_i;
  assign rs2_mag      = b_sign ? -rs2_i : rs2_i;
  assign div_zero     = (rs2_i == '0);
  assign div_ovf      = div_signed & (rs1_i == MIN_NEG) & (rs2_i == '1);

  // One restoring division step on the latched magnitudes
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;
  logic [XLEN-1:0] div_res;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dvsr_q};
  assign quo_step  = {quo_q[XLEN-2:0], ~diff[XLEN]};
  assign rem_step  = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
  assign q_fin     = q_neg_q ? -quo_step : quo_step;
  assign r_fin     = r_neg_q ? -rem_step : rem_step;
  assign div_res   = rem_sel_q ? r_fin : q_fin;

`ifdef MULDIV_ITER_MUL_EN
  // Shift-add multiplier on magnitudes; sign applied to the full product at the end
  logic [2*XLEN-1:0] mc_q;
  logic [XLEN-1:0]   mp_q;
  logic [2*XLEN-1:0] acc_q;
  logic              p_neg_q;
  logic              hi_q;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   mul_fin;

  assign acc_step = acc_q + (mp_q[0] ? mc_q : '0);
  assign prod_fin = p_neg_q ? -acc_step : acc_step;
  assign mul_fin  = hi_q ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];
`else
  // Sign-extended operands give the correct low 2*XLEN product bits for every variant
  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;

  assign a_ext   = {{XLEN{a_sign}}, rs1_i};
  assign b_ext   = {{XLEN{b_sign}}, rs2_i};
  assign prod    = a_ext * b_ext;
  assign mul_res = (op_i[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`endif

  // State register
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state selection; flush always returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (!is_div) begin
`ifdef MULDIV_ITER_MUL_EN
            state_next = S_MUL;
`else
            state_next = S_DONE;
`endif
          end else if (div_zero || div_ovf) begin
            state_next = S_DONE;
          end else begin
            state_next = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (count_q == CW'(1)) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush_i) state_next = S_IDLE;
  end

  // Datapath: latch operands on acceptance, iterate, and register the final result
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      count_q   <= '0;
      result_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      rem_sel_q <= 1'b0;
`ifdef MULDIV_ITER_MUL_EN
      mc_q      <= '0;
      mp_q      <= '0;
      acc_q     <= '0;
      p_neg_q   <= 1'b0;
      hi_q      <= 1'b0;
`endif
    end else if (!flush_i) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!is_div) begin
`ifdef MULDIV_ITER_MUL_EN
              mc_q    <= {{XLEN{1'b0}}, rs1_mag};
              mp_q    <= rs2_mag;
              acc_q   <= '0;
              p_neg_q <= a_sign ^ b_sign;
              hi_q    <= (op_i[1:0] != 2'b00);
              count_q <= ITER_COUNT;
`else
              result_q <= mul_res;
`endif
            end else if (div_zero) begin
              result_q <= op_i[1] ? rs1_i : '1;
            end else if (div_ovf) begin
              result_q <= op_i[1] ? '0 : MIN_NEG;
            end else begin
              quo_q     <= rs1_mag;
              rem_q     <= '0;
              dvsr_q    <= rs2_mag;
              q_neg_q   <= a_sign ^ b_sign;
              r_neg_q   <= a_sign;
              rem_sel_q <= op_i[1];
              count_q   <= ITER_COUNT;
            end
          end
        end
        S_DIV: begin
          quo_q   <= quo_step;
          rem_q   <= rem_step;
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) result_q <= div_res;
        end
`ifdef MULDIV_ITER_MUL_EN
        S_MUL: begin
          acc_q   <= acc_step;
          mc_q    <= {mc_q[2*XLEN-2:0], 1'b0};
          mp_q    <= {1'b0, mp_q[XLEN-1:1]};
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) result_q <= mul_fin;
        end
`endif
        default: ;
      endcase
    end
  end

  assign result_o    = result_q;
  assign done_o      = (state == S_DONE) & ~flush_i;
  assign busy_o      = (state != S_IDLE);
  assign stall_req_o = n_rst_i & (accept | (state == S_MUL) | (state == S_DIV));

endmodule

// File: tb/tb_exu_muldiv.sv
// tb_exu_muldiv: directed-vector self-checking bench for exu_muldiv.
// Multiply latency follows the MULDIV_ITER_MUL_EN build macro.
module tb_exu_muldiv;

  logic        clk_i;
  logic        n_rst_i;
  logic        flush_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [31:0] result_o;
  logic        done_o;
  logic        stall_req_o;
  logic        busy_o;

  int compared = 0;
  int mismatched = 0;

`ifdef MULDIV_ITER_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 1;
`endif
  localparam int DIV_LAT = 33;

  exu_muldiv #(.XLEN(32)) dut (
    .clk_i       (clk_i),
    .n_rst_i     (n_rst_i),
    .flush_i     (flush_i),
    .start_i     (start_i),
    .op_i        (op_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .result_o    (result_o),
    .done_o      (done_o),
    .stall_req_o (stall_req_o),
    .busy_o      (busy_o)
  );

  // 10 ns clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Count one comparison and report it if the observed value differs
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Offer an op at the current negedge, hold start until done, then check result and latency
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected, input int lat);
    int  cyc;
    bit  seen;
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    #1;
    checkOutput({tag, "_stall_c0"}, {31'd0, stall_req_o}, 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == lat - 1) checkOutput({tag, "_stall_last"}, {31'd0, stall_req_o}, 32'd1);
      rs1_i = $urandom;
      rs2_i = $urandom;
      if (done_o) seen = 1'b1;
    end
    checkOutput({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    checkOutput({tag, "_latency"}, cyc, lat);
    checkOutput({tag, "_result"}, result_o, expected);
    checkOutput({tag, "_stall_done"}, {31'd0, stall_req_o}, 32'd0);
    start_i = 1'b0;
    @(negedge clk_i);
    checkOutput({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
  endtask

  // Start DIV 100/7, abort at cycle 10 by flush or reset, then run a MUL at cycle 11
  task automatic applyAbort(input string tag, input bit use_reset);
    bit saw_done;
    start_i  = 1'b1;
    op_i     = 3'd4;
    rs1_i    = 32'd100;
    rs2_i    = 32'd7;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (done_o) saw_done = 1'b1;
    end
    checkOutput({tag, "_busy_c10"}, {31'd0, busy_o}, 32'd1);
    start_i = 1'b0;
    if (use_reset) n_rst_i = 1'b0;
    else           flush_i = 1'b1;
    #1;
    if (use_reset) checkOutput({tag, "_rst_stall"}, {31'd0, stall_req_o}, 32'd0);
    @(negedge clk_i);
    n_rst_i = 1'b1;
    flush_i = 1'b0;
    if (done_o) saw_done = 1'b1;
    checkOutput({tag, "_no_done"}, {31'd0, saw_done}, 32'd0);
    checkOutput({tag, "_busy_c11"}, {31'd0, busy_o}, 32'd0);
    applyStimulus({tag, "_mul"}, 3'd0, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, MUL_LAT);
  endtask

  // Main directed sequence
  initial begin
    n_rst_i = 1'b0;
    flush_i = 1'b0;
    start_i = 1'b1;
    op_i    = 3'd4;
    rs1_i   = 32'd100;
    rs2_i   = 32'd7;
    #12;
    checkOutput("reset_result", result_o, 32'd0);
    checkOutput("reset_done", {31'd0, done_o}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset_stall", {31'd0, stall_req_o}, 32'd0);
    start_i = 1'b0;
    @(negedge clk_i);
    n_rst_i = 1'b1;
    @(negedge clk_i);

    applyStimulus("div_100_7",    3'd4, 32'd100,         32'd7,           32'd14,          DIV_LAT);
    applyStimulus("rem_m7_2",     3'd6, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   DIV_LAT);
    applyStimulus("divu_max_1",   3'd5, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   DIV_LAT);
    applyStimulus("div_m100_7",   3'd4, 32'hFFFF_FF9C,   32'd7,           32'hFFFF_FFF2,   DIV_LAT);
    applyStimulus("rem_m100_7",   3'd6, 32'hFFFF_FF9C,   32'd7,           32'hFFFF_FFFE,   DIV_LAT);
    applyStimulus("remu_100_7",   3'd7, 32'd100,         32'd7,           32'd2,           DIV_LAT);
    applyStimulus("divu_5_0",     3'd5, 32'd5,           32'd0,           32'hFFFF_FFFF,   1);
    applyStimulus("remu_5_0",     3'd7, 32'd5,           32'd0,           32'd5,           1);
    applyStimulus("rem_m5_0",     3'd6, 32'hFFFF_FFFB,   32'd0,           32'hFFFF_FFFB,   1);
    applyStimulus("div_ovf",      3'd4, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1);
    applyStimulus("rem_ovf",      3'd6, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1);
    applyStimulus("mulh_min",     3'd1, 32'h8000_0000,   32'h8000_0000,   32'h4000_0000,   MUL_LAT);
    applyStimulus("mulhsu_ones",  3'd2, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'hFFFF_FFFF,   MUL_LAT);
    applyStimulus("mulhu_ones",   3'd3, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'hFFFF_FFFE,   MUL_LAT);
    applyStimulus("mul_3_m4",     3'd0, 32'd3,           32'hFFFF_FFFC,   32'hFFFF_FFF4,   MUL_LAT);
    applyStimulus("mul_ones",     3'd0, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'd1,           MUL_LAT);
    applyStimulus("mulh_m1_m1",   3'd1, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'd0,           MUL_LAT);

    // flush wins over start in IDLE
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = 3'd0;
    #1;
    checkOutput("flush_idle_stall", {31'd0, stall_req_o}, 32'd0);
    @(negedge clk_i);
    start_i = 1'b0;
    flush_i = 1'b0;
    checkOutput("flush_idle_busy", {31'd0, busy_o}, 32'd0);

    applyAbort("flush_div", 1'b0);
    applyAbort("reset_div", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
